// File: rtl/xoodyak_pkg.sv
// Shared constants for the xoodyak output path: default widths, word counts,
// FSM state encodings and an index-width helper.
package xoodyak_pkg;

    localparam int XOO_WORD_W = 32;
    localparam int XOO_TEXT_W = 192;
    localparam int XOO_TAG_W  = 128;

    localparam int TEXT_WORDS = XOO_TEXT_W / XOO_WORD_W;
    localparam int TAG_WORDS  = XOO_TAG_W / XOO_WORD_W;

    // Never returns 0, so a single-entry array still gets a 1-bit index.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int CNT_W = idx_w((TEXT_WORDS > TAG_WORDS) ? TEXT_WORDS : TAG_WORDS);

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE      = 2'd0;
    localparam state_t ST_CHECK     = 2'd1;
    localparam state_t ST_SEND_TEXT = 2'd2;
    localparam state_t ST_SEND_TAG  = 2'd3;

endpackage

// File: rtl/xoodyak_tag_cmp.sv
// Constant-time tag equality: the whole XOR vector is OR-reduced every cycle,
// with the result registered (1-cycle latency).
module xoodyak_tag_cmp
    import xoodyak_pkg::*;
#(
    parameter int W = XOO_TAG_W
) (
    input  logic         eph1,
    input  logic         reset,
    input  logic [W-1:0] i_a,
    input  logic [W-1:0] i_b,
    output logic         o_eq
);

    logic r_eq;

    always_ff @(posedge eph1) begin
        if (!reset) begin
            r_eq <= 1'b0;
        end else begin
            r_eq <= ~|(i_a ^ i_b);
        end
    end

    assign o_eq = r_eq;

endmodule

// File: rtl/xoodyak_out_stream.sv
// Captures the core's wide text/tag result on sqzdone and streams it LSW-first
// as WORD_W words; decrypt results are released only after a tag match.
module xoodyak_out_stream
    import xoodyak_pkg::*;
#(
    parameter int WORD_W = XOO_WORD_W,
    parameter int TEXT_W = XOO_TEXT_W,
    parameter int TAG_W  = XOO_TAG_W
) (
    input  logic              eph1,
    input  logic              reset,
    input  logic              sqzdone,
    input  logic              opmode,
    input  logic [TEXT_W-1:0] textout,
    input  logic [TAG_W-1:0]  authdata,
    input  logic [TAG_W-1:0]  exp_tag,
    output logic [WORD_W-1:0] o_data,
    output logic              o_valid,
    input  logic              o_ready,
    output logic              o_last,
    output logic              busy,
    output logic              auth_ok,
    output logic              auth_fail,
    output logic              overrun
);

    localparam int N_TEXT = TEXT_W / WORD_W;
    localparam int N_TAG  = TAG_W / WORD_W;
    localparam int W_CNT  = idx_w((N_TEXT > N_TAG) ? N_TEXT : N_TAG);
    localparam int W_TXI  = idx_w(N_TEXT);
    localparam int W_TGI  = idx_w(N_TAG);

    localparam logic [W_CNT-1:0] TEXT_LAST = W_CNT'(N_TEXT - 1);
    localparam logic [W_CNT-1:0] TAG_LAST  = W_CNT'(N_TAG - 1);

    state_t             r_state;
    logic [W_CNT-1:0]   r_cnt;
    logic [TEXT_W-1:0]  r_text;
    logic [TAG_W-1:0]   r_tag;
    logic [TAG_W-1:0]   r_exp;
    logic               r_mode;
    logic               r_overrun;

    logic [WORD_W-1:0]  w_text_words [N_TEXT];
    logic [WORD_W-1:0]  w_tag_words  [N_TAG];
    logic [WORD_W-1:0]  w_sel_word;
    logic               w_sending;
    logic               w_final_pos;
    logic               w_hs;
    logic               w_final_hs;
    logic               w_capture;
    logic               w_eq;
    logic [TAG_W-1:0]   w_cmp_a;
    logic [TAG_W-1:0]   w_cmp_b;

    genvar gi;
    generate
        for (gi = 0; gi < N_TEXT; gi++) begin : g_text_words
            assign w_text_words[gi] = r_text[gi*WORD_W +: WORD_W];
        end
        for (gi = 0; gi < N_TAG; gi++) begin : g_tag_words
            assign w_tag_words[gi] = r_tag[gi*WORD_W +: WORD_W];
        end
    endgenerate

    // Data is forced to zero whenever nothing is being offered.
    always_comb begin
        w_sel_word = '0;
        case (r_state)
            ST_SEND_TEXT: w_sel_word = w_text_words[r_cnt[W_TXI-1:0]];
            ST_SEND_TAG:  w_sel_word = w_tag_words[r_cnt[W_TGI-1:0]];
            default:      w_sel_word = '0;
        endcase
    end

    assign w_sending   = (r_state == ST_SEND_TEXT) || (r_state == ST_SEND_TAG);
    assign w_final_pos = ((r_state == ST_SEND_TEXT) && (r_cnt == TEXT_LAST) && r_mode)
                      || ((r_state == ST_SEND_TAG) && (r_cnt == TAG_LAST));
    assign w_hs        = w_sending && o_ready;
    assign w_final_hs  = w_hs && w_final_pos;
    assign w_capture   = sqzdone && ((r_state == ST_IDLE) || w_final_hs);

    // Compare the incoming tags on the capture edge so the verdict is ready during CHECK.
    assign w_cmp_a = w_capture ? authdata : r_tag;
    assign w_cmp_b = w_capture ? exp_tag  : r_exp;

    xoodyak_tag_cmp #(
        .W (TAG_W)
    ) u_tag_cmp (
        .eph1  (eph1),
        .reset (reset),
        .i_a   (w_cmp_a),
        .i_b   (w_cmp_b),
        .o_eq  (w_eq)
    );

    always_ff @(posedge eph1) begin
        if (!reset) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_text    <= '0;
            r_tag     <= '0;
            r_exp     <= '0;
            r_mode    <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            if (w_capture) begin
                r_text  <= textout;
                r_tag   <= authdata;
                r_exp   <= exp_tag;
                r_mode  <= opmode;
                r_cnt   <= '0;
                r_state <= opmode ? ST_CHECK : ST_SEND_TEXT;
            end else begin
                case (r_state)
                    ST_CHECK: begin
                        if (w_eq) begin
                            r_state <= ST_SEND_TEXT;
                        end else begin
                            r_text  <= '0;
                            r_tag   <= '0;
                            r_exp   <= '0;
                            r_mode  <= 1'b0;
                            r_state <= ST_IDLE;
                        end
                    end
                    ST_SEND_TEXT: begin
                        if (w_hs) begin
                            if (r_cnt != TEXT_LAST) begin
                                r_cnt <= r_cnt + W_CNT'(1);
                            end else if (r_mode) begin
                                r_text  <= '0;
                                r_tag   <= '0;
                                r_exp   <= '0;
                                r_mode  <= 1'b0;
                                r_cnt   <= '0;
                                r_state <= ST_IDLE;
                            end else begin
                                r_cnt   <= '0;
                                r_state <= ST_SEND_TAG;
                            end
                        end
                    end
                    ST_SEND_TAG: begin
                        if (w_hs) begin
                            if (r_cnt != TAG_LAST) begin
                                r_cnt <= r_cnt + W_CNT'(1);
                            end else begin
                                r_text  <= '0;
                                r_tag   <= '0;
                                r_exp   <= '0;
                                r_mode  <= 1'b0;
                                r_cnt   <= '0;
                                r_state <= ST_IDLE;
                            end
                        end
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end
            if (sqzdone && !w_capture) begin
                r_overrun <= 1'b1;
            end
        end
    end

    assign o_data    = w_sel_word;
    assign o_valid   = w_sending;
    assign o_last    = w_final_pos;
    assign busy      = (r_state != ST_IDLE);
    assign auth_ok   = (r_state == ST_CHECK) && w_eq;
    assign auth_fail = (r_state == ST_CHECK) && !w_eq;
    assign overrun   = r_overrun;

endmodule

// File: tb/tb_xoodyak_out_stream.sv
// Directed bench for xoodyak_out_stream: enc/dec streaming, tag check,
// backpressure, overrun, back-to-back capture and mid-stream reset.
module tb_xoodyak_out_stream;

    logic          eph1 = 1'b0;
    logic          reset = 1'b0;
    logic          sqzdone = 1'b0;
    logic          opmode = 1'b0;
    logic [191:0]  textout = '0;
    logic [127:0]  authdata = '0;
    logic [127:0]  exp_tag = '0;
    logic [31:0]   o_data;
    logic          o_valid;
    logic          o_ready = 1'b0;
    logic          o_last;
    logic          busy;
    logic          auth_ok;
    logic          auth_fail;
    logic          overrun;

    int n_checks = 0;
    int n_errors = 0;

    localparam logic [191:0] TEXT1 = 192'h4d4e4f50_51525354_55565758_41424344_45464748_494a4b4c;
    localparam logic [127:0] TAG1  = 128'h00112233_44556677_8899aabb_ccddeeff;
    localparam logic [191:0] TEXT2 = 192'h06060606_05050505_04040404_03030303_02020202_01010101;
    localparam logic [127:0] TAG2  = 128'ha4a4a4a4_a3a3a3a3_a2a2a2a2_a1a1a1a1;

    localparam logic [31:0] W1 [10] = '{
        32'h494a4b4c, 32'h45464748, 32'h41424344, 32'h55565758, 32'h51525354,
        32'h4d4e4f50, 32'hccddeeff, 32'h8899aabb, 32'h44556677, 32'h00112233};
    localparam logic [31:0] W2 [10] = '{
        32'h01010101, 32'h02020202, 32'h03030303, 32'h04040404, 32'h05050505,
        32'h06060606, 32'ha1a1a1a1, 32'ha2a2a2a2, 32'ha3a3a3a3, 32'ha4a4a4a4};

    logic [31:0] exp_w [10];

    always #5 eph1 = ~eph1;

    xoodyak_out_stream dut (
        .eph1      (eph1),
        .reset     (reset),
        .sqzdone   (sqzdone),
        .opmode    (opmode),
        .textout   (textout),
        .authdata  (authdata),
        .exp_tag   (exp_tag),
        .o_data    (o_data),
        .o_valid   (o_valid),
        .o_ready   (o_ready),
        .o_last    (o_last),
        .busy      (busy),
        .auth_ok   (auth_ok),
        .auth_fail (auth_fail),
        .overrun   (overrun)
    );

    task automatic chk(input string tag, input logic [191:0] act, input logic [191:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, req);
        end
    endtask

    task automatic tick();
        @(posedge eph1);
        #1;
    endtask

    task automatic capture(input logic [191:0] t, input logic [127:0] a,
                           input logic [127:0] e, input logic m);
        textout  = t;
        authdata = a;
        exp_tag  = e;
        opmode   = m;
        sqzdone  = 1'b1;
        tick();
        sqzdone  = 1'b0;
    endtask

    // Consumes n_take words of exp_w; o_last expected on index n_total-1.
    // sqzdone is raised during the handshake of word ovr_idx / b2b_idx.
    task automatic stream(input int n_take, input int n_total, input bit bp,
                          input bit cont, input int ovr_idx, input int b2b_idx);
        int hs = 0;
        int cyc = 0;
        logic [31:0] prev_d = '0;
        logic prev_l = 1'b0;
        logic stall = 1'b0;
        while (hs < n_take && cyc < 100) begin
            o_ready = bp ? (cyc % 3 == 0) : 1'b1;
            sqzdone = 1'b0;
            if (stall) begin
                chk("hold_valid", o_valid, 1'b1);
                chk("hold_data", o_data, prev_d);
                chk("hold_last", o_last, prev_l);
            end
            if (cont) chk("valid_cont", o_valid, 1'b1);
            stall = 1'b0;
            if (o_valid) begin
                if (o_ready) begin
                    chk("data", o_data, exp_w[hs]);
                    chk("last", o_last, hs == n_total - 1);
                    $display("hs %0d data %08h last %0b", hs, o_data, o_last);
                    if (hs == ovr_idx || hs == b2b_idx) sqzdone = 1'b1;
                    hs++;
                end else begin
                    stall  = 1'b1;
                    prev_d = o_data;
                    prev_l = o_last;
                end
            end
            cyc++;
            tick();
        end
        sqzdone = 1'b0;
        o_ready = 1'b0;
        chk("stream_count", hs, n_take);
    endtask

    initial begin
        reset = 1'b0;
        tick();
        tick();
        chk("rst_valid", o_valid, 1'b0);
        chk("rst_data", o_data, 32'h0);
        chk("rst_last", o_last, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_auth_ok", auth_ok, 1'b0);
        chk("rst_auth_fail", auth_fail, 1'b0);
        chk("rst_overrun", overrun, 1'b0);
        reset = 1'b1;
        tick();

        // Encrypt stream, then a back-to-back capture on the final handshake
        exp_w = W1;
        capture(TEXT1, TAG1, 128'h0, 1'b0);
        chk("enc_busy", busy, 1'b1);
        textout  = TEXT2;
        authdata = TAG2;
        opmode   = 1'b0;
        stream(10, 10, 1'b0, 1'b1, -1, 9);
        chk("b2b_overrun", overrun, 1'b0);
        chk("b2b_busy", busy, 1'b1);
        exp_w = W2;
        stream(10, 10, 1'b0, 1'b1, -1, -1);
        chk("enc_done_busy", busy, 1'b0);
        chk("enc_done_valid", o_valid, 1'b0);
        chk("enc_done_data", o_data, 32'h0);
        chk("enc_zero_text", dut.r_text, 192'h0);
        chk("enc_zero_tag", dut.r_tag, 128'h0);

        // Decrypt with matching tag
        capture(TEXT1, TAG1, TAG1, 1'b1);
        chk("dec_auth_ok", auth_ok, 1'b1);
        chk("dec_auth_fail", auth_fail, 1'b0);
        chk("dec_check_valid", o_valid, 1'b0);
        chk("dec_check_busy", busy, 1'b1);
        tick();
        chk("dec_auth_ok_pulse", auth_ok, 1'b0);
        exp_w = W1;
        stream(6, 6, 1'b0, 1'b1, -1, -1);
        chk("dec_done_busy", busy, 1'b0);
        chk("dec_no_tag", o_valid, 1'b0);

        // Decrypt with mismatching tag
        capture(TEXT1, TAG1, TAG1 ^ 128'h1, 1'b1);
        chk("mis_auth_fail", auth_fail, 1'b1);
        chk("mis_auth_ok", auth_ok, 1'b0);
        chk("mis_valid", o_valid, 1'b0);
        tick();
        chk("mis_busy", busy, 1'b0);
        chk("mis_fail_pulse", auth_fail, 1'b0);
        chk("mis_zero_text", dut.r_text, 192'h0);
        chk("mis_zero_tag", dut.r_tag, 128'h0);
        chk("mis_zero_exp", dut.r_exp, 128'h0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("mis_no_valid", o_valid, 1'b0);
        end

        // Backpressure plus an overrun strobe at word 3
        exp_w = W1;
        capture(TEXT1, TAG1, 128'h0, 1'b0);
        textout  = TEXT2;
        authdata = TAG2;
        stream(10, 10, 1'b1, 1'b0, 3, -1);
        chk("ovr_set", overrun, 1'b1);
        chk("ovr_done_busy", busy, 1'b0);

        // Reset in the middle of a stream
        exp_w = W2;
        capture(TEXT2, TAG2, 128'h0, 1'b0);
        stream(4, 10, 1'b0, 1'b1, -1, -1);
        reset = 1'b0;
        tick();
        reset = 1'b1;
        chk("mrst_valid", o_valid, 1'b0);
        chk("mrst_busy", busy, 1'b0);
        chk("mrst_overrun", overrun, 1'b0);
        chk("mrst_data", o_data, 32'h0);
        exp_w = W1;
        capture(TEXT1, TAG1, 128'h0, 1'b0);
        stream(10, 10, 1'b0, 1'b1, -1, -1);
        chk("fresh_done_busy", busy, 1'b0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
